aes_byte_stream: RTL and testbench
==================================

# aes_byte_stream

Byte-serial front/back end for the combinational AES cipher core. Collects key and plaintext bytes over a valid/ready byte stream and drives the core's 128-bit data and Nk×32-bit key inputs. After a settle interval it captures the core's 128-bit ciphertext and streams it back out byte-by-byte. It sits directly upstream and downstream of the cipher instance in the top level.

## Interface
- Nk, 4, key length in 32-bit words (4/6/8); key frame is Nk*4 bytes
- Nr, 10, round count; passed through for consistency with the cipher instance, not used internally
- SETTLE, 2, cycles allowed for the combinational cipher to settle (≥1)
- Clocking: one clock; reset is asynchronous and active-low
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input byte valid
- in_ready  out  1  block can accept a byte
- in_data  in  8  input byte
- in_key  in  1  sampled on first byte of a frame only: 1 = key bytes precede the data bytes
- cipher_data  out  128  plaintext to cipher core
- cipher_key  out  Nk*32  key to cipher core
- cipher_result  in  128  ciphertext from cipher core
- out_valid  out  1  output byte valid
- out_ready  in  1  downstream accepts byte
- out_data  out  8  ciphertext byte
- out_last  out  1  high with the 16th output byte
- key_loaded  out  1  a full key has been loaded since reset
- busy  out  1  high in any state other than IDLE

## Operation
- Transfer occurs on a rising edge where valid && ready.
- Byte order is MSB-first: the first data byte goes to cipher_data[127:120] and the 16th to [7:0]. The first key byte goes to cipher_key[Nk*32-1 -: 8]. The first output byte is ciphertext[127:120].
- FSM states: IDLE, LOAD_KEY, LOAD_DATA, WAIT, SEND.
- IDLE:
  - in_ready=1.
  - On transfer with in_key=1: store key byte 0, byte count=1, go to LOAD_KEY.
  - On transfer with in_key=0: store data byte 0, count=1, go to LOAD_DATA.
- LOAD_KEY:
  - in_ready=1; in_key is ignored.
  - Each transfer stores the next key byte.
  - On transfer of byte Nk*4: count=0, go to LOAD_DATA, set key_loaded=1.
- LOAD_DATA:
  - in_ready=1.
  - On transfer of the 16th data byte: load the wait counter with SETTLE, go to WAIT.
- WAIT:
  - in_ready=0.
  - Counter decrements each cycle.
  - On the cycle the counter is 1: capture cipher_result into the output shift register, out count=0, go to SEND.
- SEND:
  - out_valid=1; out_data = shift register [127:120].
  - On out_ready: shift left 8 and increment the count.
  - out_last=1 while count==15; its transfer returns the FSM to IDLE.
- Key register retention:
  - The key register is retained across frames; a frame with in_key=0 reuses the last key.
  - Before any key load the key is all-zero and key_loaded=0; the frame is still processed.
- The key register changes only in LOAD_KEY. The data register changes only in IDLE/LOAD_DATA. Both outputs are held stable through WAIT and SEND.
- Backpressure:
  - in_valid while in_ready=0 has no effect.
  - out_ready while out_valid=0 has no effect.
  - out_data is held while out_valid && !out_ready.

## Timing
- Reset (async assert, state sampled on the first edge after release):
  - State=IDLE.
  - in_ready=1; out_valid=0; out_last=0; busy=0; key_loaded=0.
  - out_data=0; cipher_data=0; cipher_key=0; all counters 0.
- Reset mid-frame discards the partial frame and the pending output; the key is cleared.
- in_ready is a registered-state decode with no combinational path from in_valid. out_valid/out_data/out_last are driven from registers.
- Latency: the 16th data byte is accepted at edge t. WAIT occupies cycles t+1..t+SETTLE, and out_valid is first high in cycle t+SETTLE+1.
- Throughput with continuous valid/ready: a data-only frame takes 16 + SETTLE + 16 cycles; a key frame adds Nk*4.
- Input and output never overlap; a new frame is accepted the cycle after the out_last transfer.

## Test plan
- Key frame, Nk=4 (FIPS-197 C.1):
  - Stimulus: key 000102…0f, then pt 00112233445566778899aabbccddeeff.
  - Required: out bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a; out_last on byte 16; key_loaded=1; out_valid exactly SETTLE+1 cycles after the last input byte.
- Key reuse: follow with a data-only frame of the same pt → identical ciphertext and no key bytes consumed.
- Nk=8, Nr=14 (FIPS-197 C.3): key 00…1f, pt 00112233…ff → 8e a2 b7 ca 51 67 45 bf ea fc 49 90 4b 49 60 89.
- Backpressure: random in_valid gaps and out_ready toggling at 50% → same C.1 ciphertext, in order, with out_data stable while stalled.
- Reset mid-frame: assert rst_n=0 after 20 of 32 input bytes → all outputs at reset values. A following full C.1 frame → correct ciphertext.
- Zero key:
  - Stimulus: data-only frame right after reset, all-zero key, pt 0.
  - Required: key_loaded=0 and ciphertext 66e94bd4ef8a2c3b884cfa59ca342b2e.

Source files
------------

// File: rtl/aes_byte_stream_if.sv
// Byte-stream handshake bundle for aes_byte_stream: input bytes in, ciphertext bytes out.
// The master side is whoever feeds plaintext/key bytes and drains ciphertext.
interface aes_byte_stream_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_key;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/aes_byte_stream.sv
// Byte-serial loader/unloader wrapped around a combinational AES core.
// state      | meaning
// S_IDLE     | waiting for first byte of a frame; in_key picks key or data path
// S_LOAD_KEY | shifting in the remaining Nk*4 key bytes
// S_LOAD_DATA| shifting in the 16 plaintext bytes
// S_WAIT     | letting the cipher core settle for SETTLE cycles
// S_SEND     | streaming the captured ciphertext out MSB-first
module aes_byte_stream #(
  parameter int NK     = 4,
  parameter int NR     = 10,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_byte_stream_if.slave     bus,
  output logic [127:0]         cipher_data_o,
  output logic [NK*32-1:0]     cipher_key_o,
  input  logic [127:0]         cipher_result_i,
  output logic                 key_loaded_o,
  output logic                 busy_o
);

  localparam int KEY_W     = NK * 32;
  localparam int KEY_BYTES = NK * 4;
  localparam int WAIT_W    = $clog2(SETTLE + 1);
  localparam int unused_nr = NR;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_KEY,
    S_LOAD_DATA,
    S_WAIT,
    S_SEND
  } state_t;

  state_t              state_q, state_d;
  logic [KEY_W-1:0]    key_q;
  logic [127:0]        data_q;
  logic [127:0]        out_sr_q;
  logic [5:0]          in_cnt_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [3:0]          out_cnt_q;
  logic                key_loaded_q;

  logic in_ready, out_valid;
  logic in_fire, out_fire;
  logic key_last, data_last, wait_done;

  assign in_fire   = bus.in_valid && in_ready;
  assign out_fire  = bus.out_ready && out_valid;
  assign key_last  = (in_cnt_q == 6'(KEY_BYTES - 1));
  assign data_last = (in_cnt_q == 6'd15);
  assign wait_done = (wait_q == WAIT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (in_fire) state_d = bus.in_key ? S_LOAD_KEY : S_LOAD_DATA;
      S_LOAD_KEY:  if (in_fire && key_last) state_d = S_LOAD_DATA;
      S_LOAD_DATA: if (in_fire && data_last) state_d = S_WAIT;
      S_WAIT:      if (wait_done) state_d = S_SEND;
      S_SEND:      if (out_fire && out_cnt_q == 4'd15) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy_o    = 1'b1;
    unique case (state_q)
      S_IDLE:      begin in_ready = 1'b1; busy_o = 1'b0; end
      S_LOAD_KEY:  in_ready = 1'b1;
      S_LOAD_DATA: in_ready = 1'b1;
      S_WAIT:      in_ready = 1'b0;
      S_SEND:      out_valid = 1'b1;
      default:     busy_o = 1'b1;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_sr_q[127:120];
  assign bus.out_last  = out_valid && (out_cnt_q == 4'd15);

  // Key and data are shifted in MSB-first, so after a full frame byte 0 sits at the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q        <= '0;
      data_q       <= '0;
      in_cnt_q     <= '0;
      key_loaded_q <= 1'b0;
    end else if (in_fire) begin
      if (state_q == S_LOAD_KEY || (state_q == S_IDLE && bus.in_key))
        key_q <= {key_q[KEY_W-9:0], bus.in_data};
      else
        data_q <= {data_q[119:0], bus.in_data};
      unique case (state_q)
        S_IDLE:      in_cnt_q <= 6'd1;
        S_LOAD_KEY:  begin
          in_cnt_q <= key_last ? 6'd0 : in_cnt_q + 6'd1;
          if (key_last) key_loaded_q <= 1'b1;
        end
        S_LOAD_DATA: in_cnt_q <= data_last ? 6'd0 : in_cnt_q + 6'd1;
        default:     in_cnt_q <= in_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q    <= '0;
      out_sr_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      if (in_fire && state_q == S_LOAD_DATA && data_last)
        wait_q <= WAIT_W'(SETTLE);
      else if (state_q == S_WAIT)
        wait_q <= wait_q - WAIT_W'(1);

      // Zeros shift in behind the ciphertext, so out_data returns to 0 after the frame.
      if (state_q == S_WAIT && wait_done) begin
        out_sr_q  <= cipher_result_i;
        out_cnt_q <= 4'd0;
      end else if (out_fire) begin
        out_sr_q  <= {out_sr_q[119:0], 8'h00};
        out_cnt_q <= out_cnt_q + 4'd1;
      end
    end
  end

  assign cipher_data_o = data_q;
  assign cipher_key_o  = key_q;
  assign key_loaded_o  = key_loaded_q;

endmodule

// File: tb/tb_aes_byte_stream.sv
// Self-checking bench for aes_byte_stream: Nk=4 and Nk=8 instances around a stand-in cipher core.
// The stand-in returns FIPS-197 answers for the known vectors and a keyed mix otherwise.
module tb_aes_byte_stream;
  localparam int SETTLE4 = 2;
  localparam int SETTLE8 = 3;
  localparam logic [127:0] PT      = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT_ZERO = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  aes_byte_stream_if if4();
  aes_byte_stream_if if8();

  logic [127:0] cdata4, cres4, ckey4, cdata8, cres8;
  logic [255:0] ckey8;
  logic         kl4, busy4, kl8, busy8;

  logic [127:0] m_key;
  bit           m_loaded;

  function automatic logic [127:0] core4(logic [127:0] d, logic [127:0] k);
    if (k == KEY_C1 && d == PT) return CT_C1;
    if (k == '0 && d == '0) return CT_ZERO;
    return d ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  function automatic logic [127:0] core8(logic [127:0] d, logic [255:0] k);
    if (k == KEY_C3 && d == PT) return CT_C3;
    return d ^ k[255:128] ^ k[127:0];
  endfunction

  assign cres4 = core4(cdata4, ckey4);
  assign cres8 = core8(cdata8, ckey8);

  aes_byte_stream #(.NK(4), .NR(10), .SETTLE(SETTLE4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4),
    .cipher_data_o(cdata4), .cipher_key_o(ckey4), .cipher_result_i(cres4),
    .key_loaded_o(kl4), .busy_o(busy4)
  );

  aes_byte_stream #(.NK(8), .NR(14), .SETTLE(SETTLE8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8),
    .cipher_data_o(cdata8), .cipher_key_o(ckey8), .cipher_result_i(cres8),
    .key_loaded_o(kl8), .busy_o(busy8)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    if4.in_valid = 1'b0; if4.in_key = 1'b0; if4.in_data = 8'h00; if4.out_ready = 1'b0;
    if8.in_valid = 1'b0; if8.in_key = 1'b0; if8.in_data = 8'h00; if8.out_ready = 1'b0;
    m_key = '0;
    m_loaded = 1'b0;
    #1;
    check("rst_async_busy", 256'(busy4), 256'(0));
    check("rst_async_out_valid", 256'(if4.out_valid), 256'(0));
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 256'(if4.in_ready), 256'(1));
    check("rst_out_last", 256'(if4.out_last), 256'(0));
    check("rst_key_loaded", 256'(kl4), 256'(0));
    check("rst_out_data", 256'(if4.out_data), 256'(0));
    check("rst_cipher_data", 256'(cdata4), 256'(0));
    check("rst_cipher_key", 256'(ckey4), 256'(0));
    check("rst8_cipher_key", ckey8, 256'(0));
    check("rst8_busy", 256'(busy8), 256'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame4(input bit with_key, input logic [127:0] key,
                            input logic [127:0] pt, input int gap, input int stall);
    logic [7:0]   b[$];
    logic [127:0] exp_ct;
    int           a_cyc = 0;
    int           o_cyc = 0;
    b = {};
    if (with_key) for (int i = 0; i < 16; i++) b.push_back(key[127-8*i -: 8]);
    for (int i = 0; i < 16; i++) b.push_back(pt[127-8*i -: 8]);
    if (with_key) begin
      m_key = key;
      m_loaded = 1'b1;
    end
    exp_ct = core4(pt, m_key);
    fork
      begin : prod
        int i = 0;
        int g = 0;
        while (i < b.size() && g < 3000) begin
          if4.in_valid = ($urandom_range(99) >= gap);
          if4.in_data  = b[i];
          if4.in_key   = (i == 0) ? with_key : 1'($urandom_range(1));
          @(negedge clk);
          if (if4.in_valid && if4.in_ready) begin
            i++;
            a_cyc = cyc;
          end
          @(posedge clk);
          #1;
          g++;
        end
        if4.in_valid = 1'b0;
        check("in_bytes", 256'(i), 256'(b.size()));
      end
      begin : cons
        int k = 0;
        int g = 0;
        bit held = 1'b0;
        bit first = 1'b1;
        logic [7:0] hv = 8'h00;
        while (k < 16 && g < 3000) begin
          if4.out_ready = ($urandom_range(99) >= stall);
          @(negedge clk);
          if (if4.out_valid) begin
            if (first) begin
              o_cyc = cyc;
              first = 1'b0;
              check("no_overlap", 256'(if4.in_ready), 256'(0));
            end
            if (held) check("stall_hold", 256'(if4.out_data), 256'(hv));
            check("out_last", 256'(if4.out_last), 256'(k == 15));
            if (if4.out_ready) begin
              check("out_byte", 256'(if4.out_data), 256'(exp_ct[127-8*k -: 8]));
              k++;
              held = 1'b0;
            end else begin
              held = 1'b1;
              hv = if4.out_data;
            end
          end
          @(posedge clk);
          #1;
          g++;
        end
        if4.out_ready = 1'b0;
        check("out_bytes", 256'(k), 256'(16));
      end
    join
    check("latency", 256'(o_cyc - a_cyc), 256'(SETTLE4 + 1));
    check("key_loaded", 256'(kl4), 256'(m_loaded));
    check("cipher_key", 256'(ckey4), 256'(m_key));
    check("cipher_data", 256'(cdata4), 256'(pt));
    check("idle_ready", 256'(if4.in_ready), 256'(1));
    check("idle_busy", 256'(busy4), 256'(0));
    check("idle_valid", 256'(if4.out_valid), 256'(0));
  endtask

  task automatic run_c3();
    logic [7:0]   b8[48];
    logic [255:0] kv = KEY_C3;
    logic [127:0] pv = PT;
    logic [127:0] cv = CT_C3;
    int i = 0, k = 0, g = 0, a = 0;
    for (int j = 0; j < 32; j++) b8[j] = kv[255-8*j -: 8];
    for (int j = 0; j < 16; j++) b8[32+j] = pv[127-8*j -: 8];
    if8.out_ready = 1'b1;
    while ((i < 48 || k < 16) && g < 500) begin
      if8.in_valid = (i < 48);
      if8.in_data  = b8[(i < 48) ? i : 47];
      if8.in_key   = (i == 0);
      @(negedge clk);
      if (if8.in_valid && if8.in_ready) begin
        i++;
        a = cyc;
      end
      if (if8.out_valid) begin
        if (k == 0) check("c3_latency", 256'(cyc - a), 256'(SETTLE8 + 1));
        check("c3_byte", 256'(if8.out_data), 256'(cv[127-8*k -: 8]));
        check("c3_last", 256'(if8.out_last), 256'(k == 15));
        k++;
      end
      @(posedge clk);
      #1;
      g++;
    end
    if8.in_valid = 1'b0;
    if8.out_ready = 1'b0;
    check("c3_out_bytes", 256'(k), 256'(16));
    check("c3_key_loaded", 256'(kl8), 256'(1));
    check("c3_cipher_key", ckey8, kv);
  endtask

  initial begin
    do_reset();
    // zero key, data-only frame straight after reset
    run_frame4(1'b0, '0, '0, 0, 0);
    run_frame4(1'b1, KEY_C1, PT, 0, 0);
    run_frame4(1'b0, '0, PT, 0, 0);
    run_frame4(1'b1, KEY_C1, PT, 50, 50);
    for (int r = 0; r < 6; r++)
      run_frame4(1'($urandom_range(1)),
                 {$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom},
                 int'($urandom_range(60)), int'($urandom_range(60)));
    // reset after 20 of 32 input bytes of a key frame
    begin
      logic [127:0] kv = KEY_C1;
      for (int i = 0; i < 20; i++) begin
        if4.in_valid = 1'b1;
        if4.in_key   = (i == 0);
        if4.in_data  = (i < 16) ? kv[127-8*i -: 8] : 8'(i - 16);
        @(posedge clk);
        #1;
      end
      if4.in_valid = 1'b0;
      check("mid_busy", 256'(busy4), 256'(1));
    end
    do_reset();
    run_frame4(1'b1, KEY_C1, PT, 0, 0);
    run_c3();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
